// File: rtl/send_sequencer.sv
// APB-programmed descriptor scheduler driving Send_start/Send_Length.
// Optional watchdog on the wait states: define SEND_SEQ_WATCHDOG_EN.
module send_sequencer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int START_PULSE = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        S_APB_aclk,
  input  logic        S_APB_aresetn,
  input  logic [31:0] S_APB_paddr,
  input  logic        S_APB_psel,
  input  logic        S_APB_penable,
  input  logic        S_APB_pwrite,
  input  logic [31:0] S_APB_pwdata,
  output logic [31:0] S_APB_prdata,
  output logic        S_APB_pready,
  output logic        S_APB_pslverr,
  output logic        Send_start,
  output logic [11:0] Send_Length,
  input  logic        Valid,
  output logic        Irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] PULSE_LAST = 16'(START_PULSE - 1);
  localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PULSE, S_WAIT_V, S_WAIT_D, S_GAP
  } state_t;

  state_t state, state_nx;

  logic        acc, wr;
  logic [2:0]  ofs;
  logic        wr_ctrl, wr_desc, wr_gap, wr_stat, wr_dcnt;
  logic        push, pop, flush, done, to_fire, wd_to;
  logic        enable, ovf, tmo, done_pend;
  logic [15:0] gap_reg, done_cnt, cnt;
  logic [11:0] len_q;
  logic [31:0] rdata;
  logic [11:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, level;
  logic        empty, full;

  assign acc     = S_APB_psel & S_APB_penable & ~S_APB_pready;
  assign wr      = acc & S_APB_pwrite;
  assign ofs     = S_APB_paddr[4:2];
  assign wr_ctrl = wr && ofs == 3'd0;
  assign wr_desc = wr && ofs == 3'd1;
  assign wr_gap  = wr && ofs == 3'd2;
  assign wr_stat = wr && ofs == 3'd3;
  assign wr_dcnt = wr && ofs == 3'd4;

  assign level = wp - rp;
  assign empty = (wp == rp);
  assign full  = level[AW];
  assign pop   = (state == S_LOAD) && !empty;
  assign push  = wr_desc && (!full || pop);
  assign flush = wr_ctrl && S_APB_pwdata[1];
  assign done  = (state == S_WAIT_D) && !Valid;

  // A timeout only fires when the awaited Valid edge has not arrived.
  assign to_fire = wd_to &
    ((state == S_WAIT_V) ? ~Valid : Valid);

`ifdef SEND_SEQ_WATCHDOG_EN
  logic [15:0] wd;
  assign wd_to = (state == S_WAIT_V || state == S_WAIT_D)
    && wd == WD_LIM;
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn)
    if (!S_APB_aresetn) wd <= '0;
    else if (state == S_WAIT_V || state == S_WAIT_D)
      wd <= wd + 16'd1;
    else wd <= '0;
`else
  logic unused_wd;
  assign wd_to = 1'b0;
  assign unused_wd = ^WD_LIM;
`endif

  logic unused_bits;
  assign unused_bits = ^{S_APB_paddr[31:5], S_APB_paddr[1:0],
                         S_APB_pwdata[31:16]};

  always_ff @(posedge S_APB_aclk)
    if (push) mem[wp[AW-1:0]] <= S_APB_pwdata[11:0];

  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn)
    if (!S_APB_aresetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (flush) rp <= wp;
      else if (pop) rp <= rp + 1'b1;
    end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (enable && !empty) state_nx = S_LOAD;
      S_LOAD:   state_nx = empty ? S_IDLE : S_PULSE;
      S_PULSE:  if (cnt == PULSE_LAST) state_nx = S_WAIT_V;
      S_WAIT_V: if (Valid) state_nx = S_WAIT_D;
                else if (to_fire) state_nx = S_IDLE;
      S_WAIT_D: if (!Valid)
                  state_nx = (gap_reg == '0) ? S_IDLE : S_GAP;
                else if (to_fire) state_nx = S_IDLE;
      S_GAP:    if (cnt <= 16'd1) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn)
    if (!S_APB_aresetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_nx;
      if (pop) len_q <= mem[rp[AW-1:0]];
      unique case (state)
        S_PULSE: cnt <= (state_nx == S_PULSE) ? cnt + 16'd1 : '0;
        S_WAIT_D: cnt <= done ? gap_reg : '0;
        S_GAP:   cnt <= cnt - 16'd1;
        default: cnt <= '0;
      endcase
    end

  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn)
    if (!S_APB_aresetn) begin
      enable    <= 1'b0;
      gap_reg   <= '0;
      ovf       <= 1'b0;
      tmo       <= 1'b0;
      done_pend <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (to_fire) enable <= 1'b0;
      else if (wr_ctrl) enable <= S_APB_pwdata[0];
      if (wr_gap) gap_reg <= S_APB_pwdata[15:0];
      if (wr_desc && full && !pop) ovf <= 1'b1;
      else if (wr_stat && S_APB_pwdata[10]) ovf <= 1'b0;
      if (to_fire) tmo <= 1'b1;
      else if (wr_stat && S_APB_pwdata[11]) tmo <= 1'b0;
      if (wr_dcnt) begin
        done_cnt  <= '0;
        done_pend <= 1'b0;
      end else if (done) begin
        done_cnt  <= done_cnt + 16'd1;
        done_pend <= 1'b1;
      end
    end

  always_comb begin
    rdata = '0;
    case (ofs)
      3'd0: rdata = {31'd0, enable};
      3'd2: rdata = {16'd0, gap_reg};
      3'd3: rdata = {19'd0, done_pend, tmo, ovf, full,
                     state != S_IDLE, 1'b0, 7'(level)};
      3'd4: rdata = {16'd0, done_cnt};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn)
    if (!S_APB_aresetn) begin
      S_APB_pready  <= 1'b0;
      S_APB_pslverr <= 1'b0;
      S_APB_prdata  <= '0;
    end else begin
      S_APB_pready  <= acc;
      S_APB_pslverr <= wr_desc && full && !pop;
      if (acc) S_APB_prdata <= S_APB_pwrite ? 32'd0 : rdata;
    end

  assign Send_start  = (state == S_PULSE);
  assign Send_Length = len_q;
  assign Irq         = done_pend | ovf | tmo;

endmodule
